// File: rtl/ab_pulse_mc.sv
// Multi-channel edge-triggered pulse generator: each channel turns a selected
// edge on its input into a pulse with a programmable delay and width.
module ab_pulse_mc #(
   parameter int CH   = 4,
   parameter int CW   = 8,
   parameter int SYNC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH-1:0]    check,
   input  logic [1:0]       edge_sel,
   input  logic             retrig,
   input  logic             oneshot,
   input  logic [CH-1:0]    arm,
   input  logic [CH*CW-1:0] delay,
   input  logic [CH*CW-1:0] width,
   output logic [CH-1:0]    pulse,
   output logic [CH-1:0]    busy,
   output logic [CH-1:0]    locked
);
   typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, LOCKED} state_t;

   logic [CH-1:0] s;
   logic [CH-1:0] prev;
   logic [CH-1:0] trig;

   generate
      if (SYNC == 0) begin : g_nosync
         assign s = check;
      end else begin : g_sync
         logic [CH-1:0] sync_q [SYNC];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < SYNC; k++) sync_q[k] <= '0;
            end else begin
               sync_q[0] <= check;
               for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
            end
         end
         assign s = sync_q[SYNC-1];
      end
   endgenerate

   // prev resets to 0 so an input already high at reset release reads as a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= '0;
      else     prev <= s;
   end

   assign trig = ({CH{edge_sel[0]}} & s & ~prev) | ({CH{edge_sel[1]}} & ~s & prev);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_t        state;
      logic [CW-1:0] cnt;
      logic [CW-1:0] wm1;
      logic [CW-1:0] d_in;
      logic [CW-1:0] w_in;
      logic [CW-1:0] w_in_m1;
      logic          start;
      logic          pulse_q;
      logic          busy_q;
      logic          locked_q;

      assign d_in    = delay[i*CW +: CW];
      assign w_in    = width[i*CW +: CW];
      assign w_in_m1 = (w_in == '0) ? '0 : w_in - 1'b1;
      // Timing (re)starts from IDLE, or from DELAY/ACTIVE when retrigger is enabled.
      assign start   = trig[i] && ((state == IDLE) ||
                       (retrig && (state == DELAY || state == ACTIVE)));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            wm1      <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
         end else if (start) begin
            wm1      <= w_in_m1;
            busy_q   <= 1'b1;
            locked_q <= 1'b0;
            if (d_in == '0) begin
               state   <= ACTIVE;
               cnt     <= w_in_m1;
               pulse_q <= 1'b1;
            end else begin
               state   <= DELAY;
               cnt     <= d_in - 1'b1;
               pulse_q <= 1'b0;
            end
         end else begin
            case (state)
               DELAY: begin
                  if (cnt == '0) begin
                     state   <= ACTIVE;
                     cnt     <= wm1;
                     pulse_q <= 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ACTIVE: begin
                  if (cnt == '0) begin
                     pulse_q <= 1'b0;
                     busy_q  <= 1'b0;
                     if (oneshot) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               LOCKED: begin
                  if (arm[i]) begin
                     state    <= IDLE;
                     locked_q <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end

      assign pulse[i]  = pulse_q;
      assign busy[i]   = busy_q;
      assign locked[i] = locked_q;
   end
endmodule

// File: tb/tb_ab_pulse_mc.sv
// Bench for ab_pulse_mc: two instances (SYNC=0 and SYNC=2) share stimulus and
// are compared every cycle against a time-window reference model.
module tb_ab_pulse_mc;
   localparam int CH = 4;
   localparam int CW = 8;

   typedef struct {
      logic [CH-1:0] chk;
      logic [CH-1:0] p0;
      logic [CH-1:0] p2;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [CH-1:0]    check;
   logic [1:0]       edge_sel;
   logic             retrig;
   logic             oneshot;
   logic [CH-1:0]    arm;
   logic [CH*CW-1:0] delay;
   logic [CH*CW-1:0] width;
   logic [CH-1:0]    pulse0, busy0, locked0;
   logic [CH-1:0]    pulse2, busy2, locked2;

   always #5 clk = ~clk;

   ab_pulse_mc #(.CH(CH), .CW(CW), .SYNC(0)) dut0 (
      .clk(clk), .rst(rst), .check(check), .edge_sel(edge_sel), .retrig(retrig),
      .oneshot(oneshot), .arm(arm), .delay(delay), .width(width),
      .pulse(pulse0), .busy(busy0), .locked(locked0));

   ab_pulse_mc #(.CH(CH), .CW(CW), .SYNC(2)) dut2 (
      .clk(clk), .rst(rst), .check(check), .edge_sel(edge_sel), .retrig(retrig),
      .oneshot(oneshot), .arm(arm), .delay(delay), .width(width),
      .pulse(pulse2), .busy(busy2), .locked(locked2));

   int vectors = 0;
   int errors  = 0;

   // Reference model: each channel is a window [ts, te) of edge numbers where the
   // pulse is high, plus a lock flag; index 0 models SYNC=0, index 1 SYNC=2.
   logic [CH-1:0] hist[$];
   logic [CH-1:0] m_prev   [2];
   bit            m_timing [2][CH];
   bit            m_lock   [2][CH];
   longint        m_ts     [2][CH];
   longint        m_te     [2][CH];
   logic [CH-1:0] m_pulse  [2];
   logic [CH-1:0] m_busy   [2];
   logic [CH-1:0] m_locked [2];
   longint        n_edge;

   task automatic model_reset();
      hist.delete();
      n_edge = 0;
      for (int k = 0; k < 2; k++) begin
         m_prev[k]   = '0;
         m_pulse[k]  = '0;
         m_busy[k]   = '0;
         m_locked[k] = '0;
         for (int i = 0; i < CH; i++) begin
            m_timing[k][i] = 0;
            m_lock[k][i]   = 0;
            m_ts[k][i]     = 0;
            m_te[k][i]     = 0;
         end
      end
   endtask

   task automatic model_edge();
      int            sd;
      logic [CH-1:0] sv;
      bit            tr;
      bit            running;
      longint        d;
      longint        w;
      hist.push_back(check);
      for (int k = 0; k < 2; k++) begin
         sd = (k == 0) ? 0 : 2;
         sv = (hist.size() > sd) ? hist[hist.size()-1-sd] : '0;
         for (int i = 0; i < CH; i++) begin
            tr = (edge_sel[0] && sv[i] && !m_prev[k][i]) ||
                 (edge_sel[1] && !sv[i] && m_prev[k][i]);
            d = longint'(delay[i*CW +: CW]);
            w = longint'(width[i*CW +: CW]);
            if (w == 0) w = 1;
            running = m_timing[k][i] && (n_edge <= m_te[k][i]);
            if (m_lock[k][i]) begin
               if (arm[i]) m_lock[k][i] = 0;
            end else if (tr && (!running || retrig)) begin
               m_timing[k][i] = 1;
               m_ts[k][i]     = n_edge + d;
               m_te[k][i]     = n_edge + d + w;
            end else if (running && n_edge == m_te[k][i]) begin
               m_timing[k][i] = 0;
               m_lock[k][i]   = oneshot;
            end
            m_pulse[k][i]  = m_timing[k][i] && n_edge >= m_ts[k][i] && n_edge < m_te[k][i];
            m_busy[k][i]   = m_timing[k][i] && n_edge < m_te[k][i];
            m_locked[k][i] = m_lock[k][i];
         end
         m_prev[k] = sv;
      end
      if (hist.size() > 3) void'(hist.pop_front());
      n_edge++;
   endtask

   task automatic check_dut(input int k, input logic [CH-1:0] p, input logic [CH-1:0] b,
                            input logic [CH-1:0] l);
      vectors++;
      if ({p, b, l} !== {m_pulse[k], m_busy[k], m_locked[k]}) begin
         errors++;
         $display("FAIL model_sync%0d edge=%0d pulse/busy/locked got %b/%b/%b want %b/%b/%b",
                  k * 2, n_edge, p, b, l, m_pulse[k], m_busy[k], m_locked[k]);
      end
   endtask

   task automatic expect_int(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      #1;
      check_dut(0, pulse0, busy0, locked0);
      check_dut(1, pulse2, busy2, locked2);
   endtask

   task automatic do_reset(input logic [CH-1:0] chk);
      rst   = 1'b1;
      check = chk;
      arm   = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic set_all(input logic [CW-1:0] dv, input logic [CW-1:0] wv);
      for (int i = 0; i < CH; i++) begin
         delay[i*CW +: CW] = dv;
         width[i*CW +: CW] = wv;
      end
   endtask

   initial begin
      vec_t tbl[8];
      int   pcount, bcount, pcount2, first0, first2, c;
      int   cnts[CH];

      check = '0; arm = '0; edge_sel = 2'b01; retrig = 1'b0; oneshot = 1'b0;
      set_all(8'd0, 8'd3);
      model_reset();
      do_reset('0);

      // Rising edge on ch0, delay 0, width 3; the SYNC=2 copy lags by two cycles.
      tbl[0] = '{chk: 4'h0, p0: 4'h0, p2: 4'h0};
      tbl[1] = '{chk: 4'h1, p0: 4'h1, p2: 4'h0};
      tbl[2] = '{chk: 4'h1, p0: 4'h1, p2: 4'h0};
      tbl[3] = '{chk: 4'h1, p0: 4'h1, p2: 4'h1};
      tbl[4] = '{chk: 4'h1, p0: 4'h0, p2: 4'h1};
      tbl[5] = '{chk: 4'h1, p0: 4'h0, p2: 4'h1};
      tbl[6] = '{chk: 4'h1, p0: 4'h0, p2: 4'h0};
      tbl[7] = '{chk: 4'h0, p0: 4'h0, p2: 4'h0};
      for (int j = 0; j < 8; j++) begin
         check = tbl[j].chk;
         step();
         expect_int("tbl_pulse_sync0", longint'(pulse0), longint'(tbl[j].p0));
         expect_int("tbl_pulse_sync2", longint'(pulse2), longint'(tbl[j].p2));
      end

      // Falling edge on ch1, delay 5, width 0.
      do_reset('0);
      edge_sel = 2'b10;
      set_all(8'd0, 8'd1);
      delay[CW +: CW] = 8'd5;
      width[CW +: CW] = 8'd0;
      check = 4'b0010;
      repeat (3) step();
      check = '0;
      pcount = 0; bcount = 0; first0 = -1;
      for (int j = 0; j < 12; j++) begin
         step();
         if (pulse0[1]) begin
            pcount++;
            if (first0 < 0) first0 = j;
         end
         if (busy0[1]) bcount++;
      end
      expect_int("fall_pulse_cycles", pcount, 1);
      expect_int("fall_pulse_start", first0, 5);
      expect_int("fall_busy_cycles", bcount, 6);

      // Retrigger two cycles into a 4-cycle pulse, with and without retrig.
      do_reset('0);
      edge_sel = 2'b01;
      set_all(8'd0, 8'd4);
      retrig = 1'b1;
      pcount = 0;
      for (int j = 0; j < 12; j++) begin
         check = (j == 1) ? 4'h0 : 4'h1;
         step();
         if (pulse0[0]) pcount++;
      end
      expect_int("retrig1_pulse_cycles", pcount, 6);
      retrig = 1'b0;
      check = '0;
      repeat (8) step();
      pcount = 0;
      for (int j = 0; j < 12; j++) begin
         check = (j == 1) ? 4'h0 : 4'h1;
         step();
         if (pulse0[0]) pcount++;
      end
      expect_int("retrig0_pulse_cycles", pcount, 4);

      // One-shot lock, arm re-enable, and arm coincident with an edge.
      do_reset('0);
      oneshot = 1'b1;
      set_all(8'd0, 8'd2);
      pcount = 0;
      for (int j = 0; j < 20; j++) begin
         check[0] = (j < 5 || j >= 10);
         step();
         if (pulse0[0]) pcount++;
      end
      expect_int("oneshot_pulse_cycles", pcount, 2);
      expect_int("oneshot_locked", locked0[0], 1);
      arm[0] = 1'b1;
      step();
      arm[0] = 1'b0;
      expect_int("arm_unlocks", locked0[0], 0);
      pcount = 0;
      for (int j = 0; j < 8; j++) begin
         check[0] = (j != 0);
         step();
         if (pulse0[0]) pcount++;
      end
      expect_int("rearmed_pulse_cycles", pcount, 2);
      expect_int("relocked", locked0[0], 1);
      check[0] = 1'b0;
      step();
      check[0] = 1'b1;
      arm[0] = 1'b1;
      step();
      arm[0] = 1'b0;
      expect_int("arm_with_edge_unlocks", locked0[0], 0);
      pcount = 0;
      repeat (6) begin
         step();
         if (pulse0[0]) pcount++;
      end
      expect_int("arm_with_edge_no_pulse", pcount, 0);
      oneshot = 1'b0;

      // Inputs high through reset give one initial pulse per channel.
      edge_sel = 2'b01;
      for (int i = 0; i < CH; i++) begin
         delay[i*CW +: CW] = 8'd0;
         width[i*CW +: CW] = CW'(i + 2);
      end
      do_reset('1);
      for (int i = 0; i < CH; i++) cnts[i] = 0;
      for (int j = 0; j < 10; j++) begin
         step();
         for (int i = 0; i < CH; i++) if (pulse0[i]) cnts[i]++;
      end
      for (int i = 0; i < CH; i++) expect_int("initial_pulse_width", cnts[i], i + 2);

      // Asynchronous reset in the middle of a pulse.
      set_all(8'd0, 8'd6);
      do_reset('1);
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      expect_int("async_rst_pulse", longint'({pulse0, pulse2}), 0);
      expect_int("async_rst_busy", longint'({busy0, busy2}), 0);
      model_reset();
      check = '0;
      step();
      step();
      rst = 1'b0;
      pcount = 0;
      repeat (10) begin
         step();
         if (pulse0 != '0 || pulse2 != '0) pcount++;
      end
      expect_int("no_pulse_after_rst", pcount, 0);

      // Both edges, width 1, toggling every 8 cycles: SYNC=2 lags by exactly 2.
      do_reset('0);
      edge_sel = 2'b11;
      set_all(8'd0, 8'd1);
      pcount = 0; pcount2 = 0; first0 = -1; first2 = -1;
      for (int j = 0; j < 66; j++) begin
         if (j < 64) check = ((j / 8) % 2 == 1) ? '1 : '0;
         step();
         if (pulse0[0]) begin
            pcount++;
            if (first0 < 0) first0 = j;
         end
         if (pulse2[0]) begin
            pcount2++;
            if (first2 < 0) first2 = j;
         end
      end
      expect_int("toggle_pulses_sync0", pcount, 7);
      expect_int("toggle_pulses_sync2", pcount2, 7);
      expect_int("sync2_lag", first2 - first0, 2);

      // Randomised traffic checked against the model every cycle.
      do_reset(CH'($urandom));
      for (int j = 0; j < 4000; j++) begin
         if ($urandom_range(0, 3) == 0) begin
            c = $urandom_range(0, CH - 1);
            check[c] = ~check[c];
         end
         if ($urandom_range(0, 31) == 0) edge_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) retrig = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) oneshot = 1'($urandom_range(0, 1));
         arm = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
         if ($urandom_range(0, 7) == 0) begin
            c = $urandom_range(0, CH - 1);
            delay[c*CW +: CW] = ($urandom_range(0, 31) == 0) ? CW'($urandom_range(0, 255))
                                                              : CW'($urandom_range(0, 6));
            width[c*CW +: CW] = ($urandom_range(0, 31) == 0) ? 8'd255
                                                              : CW'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 499) == 0) do_reset(CH'($urandom));
         else step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
